alu_seq: RTL and testbench



---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request (operands/opcode) and response (result) handshake channels of alu_seq.
// The master drives requests and accepts results; the slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_one;
  logic [WIDTH-1:0]     in_two;
  logic [1:0]           alu_op;
  logic [2*WIDTH-1:0]   out;
  logic                 out_zero;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_valid, in_one, in_two, alu_op, out_ready,
    input  in_ready, out, out_zero, out_valid
  );

  modport slave (
    input  in_valid, in_one, in_two, alu_op, out_ready,
    output in_ready, out, out_zero, out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: ADD/SUB (and AND) in one cycle, MUL by an iterative shift-add engine.
// Define ALU_SEQ_DIV_EN to turn opcode 11 into a restoring divider instead of bitwise AND.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_X   = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [RW-1:0]   res_q, res_d;
  logic            zero_q, zero_d;

  logic [WIDTH:0]  sub_w;
  logic [RW-1:0]   quick_res;
  logic            in_iter;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  assign in_iter = bus.alu_op[1];
  // Remainder lives in acc_q low half; dividend bits shift out of opa_q as quotient bits shift in.
  assign trial   = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
  assign diff    = trial - {1'b0, opb_q};
`else
  assign in_iter = (bus.alu_op == OP_MUL);
`endif

  assign sub_w = {1'b0, bus.in_one} - {1'b0, bus.in_two};

  always_comb begin
    quick_res = '0;
    case (bus.alu_op)
      OP_ADD:  quick_res = RW'(bus.in_one) + RW'(bus.in_two);
      OP_SUB:  quick_res = {{WIDTH{sub_w[WIDTH]}}, sub_w[WIDTH-1:0]};
`ifndef ALU_SEQ_DIV_EN
      OP_X:    quick_res = RW'(bus.in_one & bus.in_two);
`endif
      default: quick_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    res_d   = res_q;
    zero_d  = zero_q;
`ifdef ALU_SEQ_DIV_EN
    opa_d   = opa_q;
    op_d    = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opb_d   = bus.in_two;
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = RW'(bus.in_one);
`ifdef ALU_SEQ_DIV_EN
          opa_d   = bus.in_one;
          op_d    = bus.alu_op;
`endif
          if (in_iter) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            res_d   = quick_res;
            zero_d  = (quick_res == '0);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
`ifdef ALU_SEQ_DIV_EN
        if (op_q == OP_X) begin
          if (!diff[WIDTH]) begin
            acc_d = RW'(diff[WIDTH-1:0]);
            opa_d = {opa_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = RW'(trial[WIDTH-1:0]);
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
          end
        end else
`endif
        begin
          if (opb_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
        end
        // The last iteration publishes its own result so latency stays WIDTH+1 with no drain cycle.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
`ifdef ALU_SEQ_DIV_EN
          if (op_q == OP_X) begin
            res_d = {acc_d[WIDTH-1:0], opa_d};
          end else begin
            res_d = acc_d;
          end
`else
          res_d = acc_d;
`endif
          zero_d = (res_d == '0);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opb_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      opa_q   <= '0;
      op_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
`ifdef ALU_SEQ_DIV_EN
      opa_q   <= opa_d;
      op_q    <= op_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = res_q;
  assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): the driver queues expected results at accept,
// a negedge monitor pops and checks value, zero flag, latency and hold-stability.
module tb_alu_seq;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] OPX = 2'b11;

  typedef struct packed {
    logic [15:0] out;
    logic        zero;
    logic [31:0] lat;
    logic [31:0] acc;
    logic [1:0]  op;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   compared;
  int   errors;
  exp_t sb[$];
  exp_t mon_e;
  logic        prev_valid;
  logic        prev_ready;
  logic [15:0] prev_out;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a rising out_valid is a new result; a held out_valid after a refused edge must not change.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          compared++;
          errors++;
          $display("FAIL unexpected_result: got out=%h, expected no result", bus.out);
        end else begin
          mon_e = sb.pop_front();
          $display("txn op=%b out=%h zero=%b lat=%0d (expected out=%h zero=%b lat=%0d)",
                   mon_e.op, bus.out, bus.out_zero, cyc - mon_e.acc + 1,
                   mon_e.out, mon_e.zero, mon_e.lat);
          chk("result", 32'(bus.out), 32'(mon_e.out));
          chk("zero_flag", 32'(bus.out_zero), 32'(mon_e.zero));
          chk("latency", 32'(cyc - mon_e.acc + 1), mon_e.lat);
        end
      end else if (bus.out_valid && prev_valid && !prev_ready) begin
        chk("held_result", 32'(bus.out), 32'(prev_out));
      end
    end
    prev_valid = bus.out_valid;
    prev_ready = bus.out_ready;
    prev_out   = bus.out;
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [15:0] eo, input int lat, input bit push);
    int   w;
    exp_t e;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_one   = a;
    bus.in_two   = b;
    bus.alu_op   = op;
    while (!bus.in_ready && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.in_ready) begin
      compared++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 100 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) begin
      e.out  = eo;
      e.zero = (eo == 16'h0);
      e.lat  = 32'(lat);
      e.acc  = 32'(cyc);
      e.op   = op;
      sb.push_back(e);
    end
    bus.in_valid = 1'b0;
    bus.in_one   = 8'($urandom);
    bus.in_two   = 8'($urandom);
    bus.alu_op   = 2'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((!bus.in_ready || sb.size() != 0) && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_idle", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    compared     = 0;
    errors       = 0;
    cyc          = 0;
    prev_valid   = 1'b0;
    prev_ready   = 1'b0;
    prev_out     = '0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_one   = 8'd0;
    bus.in_two   = 8'd0;
    bus.alu_op   = ADD;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out", 32'(bus.out), 32'd0);
    chk("reset_out_zero", 32'(bus.out_zero), 32'd0);

    // ADD, including carry into bit 8 and the extremes
    do_op(8'd10,  8'd5,   ADD, 16'd15,    1, 1'b1);
    do_op(8'd200, 8'd100, ADD, 16'd300,   1, 1'b1);
    do_op(8'hFF,  8'hFF,  ADD, 16'h01FE,  1, 1'b1);
    do_op(8'd0,   8'd0,   ADD, 16'h0000,  1, 1'b1);

    // SUB: borrow sign-extends across the upper byte
    do_op(8'd15,  8'd7,   SUB, 16'h0008,  1, 1'b1);
    do_op(8'd5,   8'd7,   SUB, 16'hFFFE,  1, 1'b1);
    do_op(8'd9,   8'd9,   SUB, 16'h0000,  1, 1'b1);
    do_op(8'd0,   8'hFF,  SUB, 16'hFF01,  1, 1'b1);

    // MUL: in_ready low for exactly 9 cycles after accept
    drain();
    do_op(8'd3, 8'd4, MUL, 16'd12, 9, 1'b1);
    for (int i = 0; i < 9; i++) begin
      chk("mul_busy_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("mul_back_idle", 32'(bus.in_ready), 32'd1);
    do_op(8'hFF, 8'hFF, MUL, 16'hFE01, 9, 1'b1);
    do_op(8'd0,  8'd200, MUL, 16'h0000, 9, 1'b1);
    do_op(8'd200, 8'd0,  MUL, 16'h0000, 9, 1'b1);
    do_op(8'd13, 8'd11,  MUL, 16'h008F, 9, 1'b1);

    // Backpressure: result held, second request refused until handshake
    drain();
    bus.out_ready = 1'b0;
    do_op(8'd1, 8'd1, ADD, 16'd2, 1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_one   = 8'd3;
    bus.in_two   = 8'd4;
    bus.alu_op   = ADD;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out", 32'(bus.out), 32'd2);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    do_op(8'd3, 8'd4, ADD, 16'd7, 1, 1'b1);

    // Reset during BUSY aborts the multiply with no result
    drain();
    do_op(8'd7, 8'd9, MUL, 16'd63, 9, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_out", 32'(bus.out), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (15) begin
      @(posedge clk);
      #1;
    end

    // Opcode 11
`ifdef ALU_SEQ_DIV_EN
    do_op(8'd100, 8'd7,  OPX, 16'h020E, 9, 1'b1);
    do_op(8'd50,  8'd0,  OPX, 16'h32FF, 9, 1'b1);
    do_op(8'hFF,  8'd1,  OPX, 16'h00FF, 9, 1'b1);
    do_op(8'd0,   8'd5,  OPX, 16'h0000, 9, 1'b1);
`else
    do_op(8'hF0,  8'h3C, OPX, 16'h0030, 1, 1'b1);
    do_op(8'hFF,  8'h00, OPX, 16'h0000, 1, 1'b1);
    do_op(8'hFF,  8'hFF, OPX, 16'h00FF, 1, 1'b1);
`endif

    drain();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end
endmodule
